snake_head_mover: RTL
=====================

Name: snake_head_mover

Overview:
- Consumes the 2-bit direction code from the push-button navigation logic and advances the snake head one grid cell per game tick.
- Owns the tick divider, the head X/Y position registers, edge handling (wrap or wall hit) and the run/pause/dead control.
- Sits between the navigation state machine and the snake body/VGA render logic, which use HEAD_X/HEAD_Y and the STEP pulse.

Parameters:
- GRID_W, 32, grid width in cells.
- GRID_H, 24, grid height in cells.
- XW, 5, width of HEAD_X; must satisfy 2^XW >= GRID_W.
- YW, 5, width of HEAD_Y; must satisfy 2^YW >= GRID_H.
- TICK_DIV, 4, CLOCK cycles per step; must be >= 1. Set large on hardware, small in simulation.
- X_INIT, 16, head X after reset.
- Y_INIT, 12, head Y after reset.
- WRAP, 1, 1 = wrap at grid edges; 0 = wall collision ends the game.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  level; leaves IDLE and starts the game
- PAUSE  in  1  level; freezes the tick counter while RUN
- DIRECTION  in  2  requested direction: 00 right, 01 down, 10 up, 11 left
- HEAD_X  out  XW  head column
- HEAD_Y  out  YW  head row
- CUR_DIR  out  2  direction applied at the last step
- STEP  out  1  one-cycle pulse, high in the same cycle that the new HEAD_X/HEAD_Y are visible
- WRAPPED  out  1  one-cycle pulse, coincident with STEP, when that step wrapped
- HIT_WALL  out  1  sticky; high in DEAD
- RUNNING  out  1  high in RUN

Behaviour:
- Reset is CLOCK-synchronous, RESET=1 on any cycle, including mid-run or in DEAD. Next cycle: state=IDLE, HEAD_X=X_INIT, HEAD_Y=Y_INIT, CUR_DIR=00, cnt=0, STEP=0, WRAPPED=0, HIT_WALL=0, RUNNING=0.
- States are IDLE, RUN and DEAD. All outputs are registered.
- IDLE:
  - Head is held and cnt=0.
  - START=1 sampled at edge k: state=RUN and RUNNING=1 after edge k, with cnt=0.
  - This holds even if PAUSE=1 at edge k.
- RUN, PAUSE=1: cnt holds and no step occurs. PAUSE wins over the terminal count.
- RUN, PAUSE=0, cnt < TICK_DIV-1: cnt increments.
- RUN, PAUSE=0, cnt = TICK_DIV-1: cnt resets to 0 and a step is taken.
  - First step happens at edge k+TICK_DIV. Later steps follow every TICK_DIV unpaused cycles.
  - TICK_DIV=1 gives a step every cycle.
- START in RUN or DEAD is ignored.
- Step direction:
  - eff = DIRECTION, unless DIRECTION == ~CUR_DIR (a reversal: right<->left or up<->down).
  - On a reversal, eff = CUR_DIR.
  - CUR_DIR <= eff. DIRECTION is sampled only on step edges.
- Move rules: right X+1, left X-1, down Y+1, up Y-1. The other axis is unchanged.
- Edge cases, applied when moving right at X=GRID_W-1, left at X=0, down at Y=GRID_H-1, or up at Y=0:
  - WRAP=1: wrap to 0 or GRID_W-1 / GRID_H-1. STEP=1 and WRAPPED=1 for that one cycle.
  - WRAP=0: state=DEAD. Head and CUR_DIR keep their pre-step values. STEP=0, WRAPPED=0, HIT_WALL=1, RUNNING=0.
- DEAD: all outputs frozen. Exit only via RESET.
- Arithmetic: unsigned, no overflow beyond the grid. The position registers never hold values >= GRID_W or >= GRID_H.

Test Plan:
- Setup for all tests: defaults (TICK_DIV=4, 32x24, init (16,12)).
- Basic stepping: RESET, then START=1 at edge 0 with DIRECTION=00. Expected: STEP at cycles 4, 8, 12; HEAD=(17,12), (18,12), (19,12); CUR_DIR=00.
- Wrap: head at X=31 moving right, WRAP=1. Expected: next STEP gives HEAD_X=0 and WRAPPED=1 in the STEP cycle. Then going up from Y=0 gives Y=23 and WRAPPED=1.
- Reversal: CUR_DIR=00, DIRECTION=11 held. Expected: X keeps incrementing and CUR_DIR stays 00. Then DIRECTION=01 gives Y+1 and CUR_DIR=01 on the next step.
- Pause: PAUSE=1 for 10 cycles while cnt=2. Expected: no STEP, head stable. After release, STEP occurs exactly 2 cycles later.
- Wall hit: WRAP=0, Y=0, DIRECTION=10. Expected at the step edge: HIT_WALL=1, RUNNING=0, STEP=0, HEAD unchanged. A later START is ignored. RESET gives (16,12), HIT_WALL=0, state IDLE.
- Reset mid-run: RESET at cnt=3 with DIRECTION=01. Expected: next cycle HEAD=(16,12), CUR_DIR=00, RUNNING=0, and no STEP pulse.

Source files
------------

// File: rtl/snake_head_mover.sv
// snake_head_mover: advances the snake head one grid cell per game tick.
// Holds the tick divider, head position, edge handling (wrap or wall hit)
// and the IDLE/RUN/DEAD control. All outputs are registered.
module snake_head_mover #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int TICK_DIV = 4,
  parameter int X_INIT   = 16,
  parameter int Y_INIT   = 12,
  parameter bit WRAP     = 1'b1
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          START,
  input  logic          PAUSE,
  input  logic [1:0]    DIRECTION,
  output logic [XW-1:0] HEAD_X,
  output logic [YW-1:0] HEAD_Y,
  output logic [1:0]    CUR_DIR,
  output logic          STEP,
  output logic          WRAPPED,
  output logic          HIT_WALL,
  output logic          RUNNING
);

  // A one-cycle divider still needs a 1-bit counter that simply stays at 0.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);

  // Direction codes: bitwise complement of a code is its opposite.
  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [1:0]    eff_dir;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          at_edge;

  // Candidate next head position for the effective direction, plus whether
  // that move crosses a grid edge (wrapped target is computed regardless).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    eff_dir = (DIRECTION == ~CUR_DIR) ? CUR_DIR : DIRECTION;
    next_x  = HEAD_X;
    next_y  = HEAD_Y;
    at_edge = 1'b0;
    case (eff_dir)
      DIR_RIGHT: begin
        if (HEAD_X == X_MAX) begin
          next_x  = '0;
          at_edge = 1'b1;
        end else begin
          next_x = HEAD_X + XW'(1);
        end
      end
      DIR_LEFT: begin
        if (HEAD_X == '0) begin
          next_x  = X_MAX;
          at_edge = 1'b1;
        end else begin
          next_x = HEAD_X - XW'(1);
        end
      end
      DIR_DOWN: begin
        if (HEAD_Y == Y_MAX) begin
          next_y  = '0;
          at_edge = 1'b1;
        end else begin
          next_y = HEAD_Y + YW'(1);
        end
      end
      DIR_UP: begin
        if (HEAD_Y == '0) begin
          next_y  = Y_MAX;
          at_edge = 1'b1;
        end else begin
          next_y = HEAD_Y - YW'(1);
        end
      end
      default: ;
    endcase
  end

  // Control FSM, tick divider and registered head/status outputs.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      HEAD_X   <= XW'(X_INIT);
      HEAD_Y   <= YW'(Y_INIT);
      CUR_DIR  <= DIR_RIGHT;
      STEP     <= 1'b0;
      WRAPPED  <= 1'b0;
      HIT_WALL <= 1'b0;
      RUNNING  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          STEP    <= 1'b0;
          WRAPPED <= 1'b0;
          cnt     <= '0;
          if (START) begin
            state   <= S_RUN;
            RUNNING <= 1'b1;
          end
        end

        S_RUN: begin
          STEP    <= 1'b0;
          WRAPPED <= 1'b0;
          // Pause freezes the divider, even on the terminal count.
          if (!PAUSE) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (at_edge && !WRAP) begin
                // Wall hit: head and direction keep their pre-step values.
                state    <= S_DEAD;
                HIT_WALL <= 1'b1;
                RUNNING  <= 1'b0;
              end else begin
                HEAD_X  <= next_x;
                HEAD_Y  <= next_y;
                CUR_DIR <= eff_dir;
                STEP    <= 1'b1;
                WRAPPED <= at_edge;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        S_DEAD: begin
          // Everything frozen until RESET.
          STEP    <= 1'b0;
          WRAPPED <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          RUNNING <= 1'b0;
        end
      endcase
    end
  end

endmodule
